// File: rtl/rr_arb_mux_pkg.sv
// Shared types for the round-robin / fixed-priority arbitrated output register.
package rr_arb_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Producer-side valid/ready channels plus the single consumer-side output channel.
interface rr_arb_mux_if #(
  parameter int N        = 5,
  parameter int CHANNELS = 32
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*N-1:0] in_data;
  logic [CHANNELS-1:0]   in_valid;
  logic [CHANNELS-1:0]   in_ready;
  logic [N-1:0]          out_data;
  logic                  out_valid;
  logic [SEL_W-1:0]      out_select;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_select
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_select
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin starting after ptr.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter  int CHANNELS = 32,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  arb_mode_t           mode,
  input  logic                enable,
  output logic                grant_valid,
  output logic [SEL_W-1:0]    grant_idx,
  output logic [CHANNELS-1:0] grant_onehot
);

  logic             found;
  logic [SEL_W:0]   cand;

  // One extra bit on cand so ptr+k never overflows before the wrap at CHANNELS.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mode == ARB_RR) begin
        cand = {1'b0, ptr} + (SEL_W+1)'(k + 1);
        if (cand >= (SEL_W+1)'(CHANNELS)) begin
          cand = cand - (SEL_W+1)'(CHANNELS);
        end
      end else begin
        cand = (SEL_W+1)'(k);
      end
      if (!found && req[cand[SEL_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SEL_W-1:0];
      end
    end
  end

  assign grant_valid = found && enable;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_valid && (grant_idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrated N-bit mux with valid/ready on every input and a single registered output stage.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int N        = 5,
  parameter  int CHANNELS = 32,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  rr_arb_mux_if.slave       bus
);

  logic [SEL_W-1:0]    ptr_reg;
  logic [N-1:0]        data_reg;
  logic [SEL_W-1:0]    select_reg;
  logic                valid_reg;

  logic                load_en;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant_idx;
  logic [CHANNELS-1:0] grant_onehot;
  logic [N-1:0]        lane_masked [CHANNELS];
  logic [N-1:0]        sel_data;

  // Nothing is accepted while reset is held, since no edge will capture it.
  assign load_en = rst_n && (!valid_reg || bus.out_ready);

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .req          (bus.in_valid),
    .ptr          (ptr_reg),
    .mode         (arb_mode_t'(mode)),
    .enable       (load_en),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  assign bus.in_ready = grant_onehot;

  // AND-OR select keeps unknowns on non-granted lanes out of the result.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign lane_masked[gi] = bus.in_data[gi*N +: N] & {N{grant_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | lane_masked[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg    <= SEL_W'(CHANNELS - 1);
      data_reg   <= '0;
      select_reg <= '0;
      valid_reg  <= 1'b0;
    end else if (grant_valid) begin
      ptr_reg    <= grant_idx;
      data_reg   <= sel_data;
      select_reg <= grant_idx;
      valid_reg  <= 1'b1;
    end else if (valid_reg && bus.out_ready) begin
      valid_reg  <= 1'b0;
    end
  end

  assign bus.out_data   = data_reg;
  assign bus.out_valid  = valid_reg;
  assign bus.out_select = select_reg;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered N-bit multiplexer with a valid/ready handshake on every input channel and on the output.
- Arbitrates among CHANNELS requesters and selects one per cycle, either by fixed priority or by round-robin (run-time selectable).
- Delivers the winner through one output register, with full back-pressure support.
- Successor to the combinational mux tree; used wherever several producers share one consumer.

Parameters:
- N, 5: data width per channel.
- CHANNELS, 32: number of input channels (≥2; need not be a power of 2).
- SEL_W, $clog2(CHANNELS): localparam, width of the select/index fields; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- in_data  input  CHANNELS*N  packed channel data; channel i occupies bits [i*N +: N].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept; at most one bit high.
- out_data  output  N  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_select  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the system's job):
  - out_valid=0, out_data=0, out_select=0.
  - Round-robin pointer ptr=CHANNELS-1, so the first round-robin search starts at 0.
- load_en = !out_valid || out_ready. The output register accepts a new word when empty or draining this cycle.
- Grant, combinational from in_valid, mode, ptr:
  - mode 0: lowest i with in_valid[i]=1.
  - mode 1: first i with in_valid[i]=1, searching ptr+1, ptr+2, … and wrapping from CHANNELS-1 to 0. The wrap is at CHANNELS, not 2^SEL_W.
  - No valid inputs: no grant.
- in_ready[i] = load_en && grant exists && grant==i. This is combinational, may depend on in_valid, and is 0 for all bits when no grant.
- Transfer on channel g at a clock edge where in_valid[g] && in_ready[g]:
  - out_data<=in_data[g], out_select<=g, out_valid<=1, ptr<=g.
  - ptr updates in both modes.
- Output handshake:
  - Output transfer when out_valid && out_ready.
  - If an output transfer occurs and no input transfer occurs, out_valid<=0. out_data and out_select keep their last values.
  - Simultaneous output and input transfer: the new word is loaded, out_valid stays 1. Throughput is 1 word/cycle.
- Stability: while out_valid && !out_ready, out_data and out_select must not change and in_ready=0.
- Latency: input transfer at edge k makes the word visible on out_data after edge k. One cycle, no combinational in-to-out path.
- Mode change: takes effect in the same cycle's grant computation. ptr is retained across mode changes.
- Fairness:
  - mode 1: a continuously-valid channel waits at most CHANNELS-1 transfers.
  - mode 0: may starve higher indices (intended).
- in_data of non-granted channels is ignored; X on those lanes must not propagate.
- Reset mid-operation discards any held word; no partial state survives.
- Unknown mode (X) is not a supported condition.

Decomposition:
- Package rr_arb_mux_pkg: enum arb_mode_t {ARB_FIXED=1'b0, ARB_RR=1'b1}.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req[CHANNELS], ptr, mode, enable.
  - Outputs: grant_valid, grant_idx[SEL_W], grant_onehot[CHANNELS].
- The top level holds ptr, the output register and the data select.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with out_valid=1 → out_valid=0, out_data=0, out_select=0, in_ready=0 immediately. After release, with all 32 valid and mode=1, the first out_select=0.
- Fixed priority (mode=0, out_ready=1): in_valid bits 3 and 17 held high, in_data[3]=5'h0A, in_data[17]=5'h11 → out_select=3, out_data=5'h0A every cycle and in_ready[17] never high. Drop in_valid[3] → next word out_select=17, out_data=5'h11.
- Round-robin (mode=1, out_ready=1): all 32 in_valid=1 → out_select sequence 0,1,…,31,0,1 on consecutive cycles with out_valid continuously 1.
- Back-pressure: hold out_ready=0 for 4 cycles with out_valid=1 → out_data/out_select unchanged and in_ready=0 throughout. Raise out_ready → same cycle in_ready for the next grant, new word on the next edge.
- Non-power-of-2 (CHANNELS=5, mode=1): in_valid=5'b10001 constant, out_ready=1 → out_select 0,4,0,4 (wrap from 4 to 0, indices 5–7 never produced).
- Idle/drain: single word on channel 2 then in_valid=0, out_ready=1 → out_valid high exactly one cycle, then 0 with out_data retained at the channel-2 value.
